ysyx_24090013_pcgen: RTL and testbench

Parametrised program-counter generator for the NPC fetch front end, replacing the fixed-width, free-running PC register. It holds the architectural PC, issues fetch requests to the IFU over a valid/ready handshake, and advances sequentially by one instruction per accepted request. It also accepts branch/jump redirects and trap/`mret` redirects with fixed priority, and halts on `ebreak`. It sits between the WBU/EXU redirect paths and the IFU request port.

---
 rtl/ysyx_24090013_pkg.sv | 13 +
 rtl/ysyx_24090013_Reg.sv | 22 ++
 rtl/ysyx_24090013_pcgen.sv | 166 ++++++++++++++++
 tb/tb_ysyx_24090013_pcgen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090013_pkg.sv
// Shared definitions for the NPC fetch front end: PC generator FSM encoding
// and the default reset vector.
package ysyx_24090013_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pcgen_state_t;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24090013_Reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_24090013_Reg #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Reset has priority over any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_24090013_pcgen.sv
// Program-counter generator for the fetch front end. Holds the architectural
// PC, presents it to the IFU over valid/ready, steps by INST_BYTES per accepted
// request and follows trap/mret and branch redirects (trap wins). Freezes on
// ebreak until reset.
//
// Build option: YSYX_24090013_PC_ALIGN_CHECK_EN
//   defined   - misaligned redirect targets are rejected and reported on
//               misalign/misalign_pc for one cycle; the PC holds.
//   undefined - low target bits are cleared and the redirect is taken;
//               misalign/misalign_pc are tied to 0.
module ysyx_24090013_pcgen
    import ysyx_24090013_pkg::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEFAULT),
    parameter int unsigned      INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    input  logic            req_ready,
    output logic            req_valid,
    output logic [XLEN-1:0] req_pc,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

    logic            reset_hi;
    pcgen_state_t    state_q, state_d;
    logic [1:0]      state_raw;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;

`ifdef YSYX_24090013_PC_ALIGN_CHECK_EN
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_pc_q, mis_pc_d;
`endif

    assign reset_hi = ~rst;
    assign state_q  = pcgen_state_t'(state_raw);

    ysyx_24090013_Reg #(
        .WIDTH     (2),
        .RESET_VAL (BOOT)
    ) u_state_reg (
        .clk  (clk),
        .rst  (reset_hi),
        .wen  (1'b1),
        .din  (state_d),
        .dout (state_raw)
    );

    ysyx_24090013_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_VEC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (reset_hi),
        .wen  (1'b1),
        .din  (pc_d),
        .dout (pc_q)
    );

`ifdef YSYX_24090013_PC_ALIGN_CHECK_EN
    ysyx_24090013_Reg #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_mis_reg (
        .clk  (clk),
        .rst  (reset_hi),
        .wen  (1'b1),
        .din  (mis_d),
        .dout (mis_q)
    );

    ysyx_24090013_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL ('0)
    ) u_mis_pc_reg (
        .clk  (clk),
        .rst  (reset_hi),
        .wen  (1'b1),
        .din  (mis_pc_d),
        .dout (mis_pc_q)
    );
`endif

    // Winning redirect: trap/mret over branch; a losing branch is never examined.
    always_comb begin
        redir_valid = 1'b0;
        redir_pc    = '0;
        if (trap_valid) begin
            redir_valid = 1'b1;
            redir_pc    = trap_pc;
        end else if (br_valid) begin
            redir_valid = 1'b1;
            redir_pc    = br_pc;
        end
    end

    // FSM next state and next PC selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef YSYX_24090013_PC_ALIGN_CHECK_EN
        mis_d    = 1'b0;
        mis_pc_d = mis_pc_q;
`endif
        unique case (state_q)
            BOOT: begin
                // One idle cycle; redirects are ignored here.
                state_d = RUN;
            end
            RUN: begin
                if (halt) begin
                    // Halt discards same-cycle redirects and increment.
                    state_d = HALT;
                end else if (redir_valid) begin
`ifdef YSYX_24090013_PC_ALIGN_CHECK_EN
                    if ((redir_pc & ALIGN_MASK) != '0) begin
                        mis_d    = 1'b1;
                        mis_pc_d = redir_pc;
                    end else begin
                        pc_d = redir_pc;
                    end
`else
                    pc_d = redir_pc & ~ALIGN_MASK;
`endif
                end else if (req_ready) begin
                    // req_valid is 1 throughout RUN, so ready alone is the handshake.
                    pc_d = pc_q + PC_STEP;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Outputs decode registered state only.
    always_comb begin
        req_valid = (state_q == RUN);
        halted    = (state_q == HALT);
        req_pc    = pc_q;
`ifdef YSYX_24090013_PC_ALIGN_CHECK_EN
        misalign    = mis_q;
        misalign_pc = mis_pc_q;
`else
        misalign    = 1'b0;
        misalign_pc = '0;
`endif
    end

endmodule

// File: tb/tb_ysyx_24090013_pcgen.sv
// Scoreboard bench for ysyx_24090013_pcgen. Each scenario task builds a table of
// per-cycle stimulus with the response expected after the following edge.
module tb_ysyx_24090013_pcgen;
    import ysyx_24090013_pkg::*;

`ifdef YSYX_24090013_PC_ALIGN_CHECK_EN
    localparam bit AEN = 1'b1;
`else
    localparam bit AEN = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        halt;
        logic        tv;
        logic [31:0] tpc;
        logic        bv;
        logic [31:0] bpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_halted;
        logic        e_mis;
        logic [31:0] e_mpc;
    } row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic        req_ready = 1'b0;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        halted;
    logic        misalign;
    logic [31:0] misalign_pc;

    logic [66:0] exp_q[$];
    logic [66:0] obs, expv;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] mpc_hold = '0;

    always #5 clk = ~clk;

    ysyx_24090013_pcgen dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .trap_valid  (trap_valid),
        .trap_pc     (trap_pc),
        .br_valid    (br_valid),
        .br_pc       (br_pc),
        .req_ready   (req_ready),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .halted      (halted),
        .misalign    (misalign),
        .misalign_pc (misalign_pc)
    );

    function automatic row_t r(logic rs, logic h, logic tv, logic [31:0] tpc, logic bv,
                               logic [31:0] bpc, logic rdy, logic ev, logic [31:0] epc,
                               logic eh, logic em, logic [31:0] empc);
        row_t x;
        x = '{rs, h, tv, tpc, bv, bpc, rdy, ev, epc, eh, em, empc};
        return x;
    endfunction

    task automatic drive(input row_t x);
        rst        = x.rst;
        halt       = x.halt;
        trap_valid = x.tv;
        trap_pc    = x.tpc;
        br_valid   = x.bv;
        br_pc      = x.bpc;
        req_ready  = x.rdy;
        exp_q.push_back({x.e_valid, x.e_pc, x.e_halted, x.e_mis, x.e_mpc});
    endtask

    task automatic test_reset();
        row_t rows[$];
        // Reset dominates halt, redirects and a pending handshake.
        rows.push_back(r(0, 1, 1, 32'h8000_1000, 1, 32'h8000_0200, 1, 0, 32'h8000_0000, 0, 0, 0));
        rows.push_back(r(0, 1, 1, 32'h8000_1000, 1, 32'h8000_0200, 1, 0, 32'h8000_0000, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
    endtask

    task automatic test_boot_sequence();
        row_t rows[$];
        // BOOT cycle: redirects are ignored.
        rows.push_back(r(1, 0, 1, 32'h8000_1000, 1, 32'h8000_0200, 1, 1, 32'h8000_0000, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0004, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0008, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_000C, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0010, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL boot[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        for (int k = 0; k < 3; k++)
            rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0010, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0014, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
    endtask

    task automatic test_redirect_priority();
        row_t rows[$];
        // Trap beats branch, applied without a handshake.
        rows.push_back(r(1, 0, 1, 32'h8000_1000, 1, 32'h8000_0200, 0, 1, 32'h8000_1000, 0, 0, 0));
        // Branch beats increment.
        rows.push_back(r(1, 0, 0, 0, 1, 32'h8000_0020, 1, 1, 32'h8000_0020, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0024, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0028, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_002C, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL redirect[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
    endtask

    task automatic test_halt();
        row_t rows[$];
        rows.push_back(r(1, 1, 0, 0, 1, 32'h8000_0200, 1, 0, 32'h8000_002C, 1, 0, 0));
        // Everything but reset is ignored in HALT.
        for (int k = 0; k < 10; k++)
            rows.push_back(r(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                             1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                             0, 32'h8000_002C, 1, 0, 0));
        rows.push_back(r(0, 1, 0, 0, 0, 0, 1, 0, 32'h8000_0000, 0, 0, 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL halt[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
    endtask

    task automatic test_misalign();
        row_t rows[$];
        // PC is 80000000 in RUN on entry.
        rows.push_back(r(1, 0, 0, 0, 1, 32'h8000_0102, 1, 1,
                         AEN ? 32'h8000_0000 : 32'h8000_0100, 0, AEN, AEN ? 32'h8000_0102 : 0));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 1,
                         AEN ? 32'h8000_0000 : 32'h8000_0100, 0, 0, AEN ? 32'h8000_0102 : 0));
        // Losing misaligned branch is not checked.
        rows.push_back(r(1, 0, 1, 32'h8000_0400, 1, 32'h8000_0003, 0, 1,
                         32'h8000_0400, 0, 0, AEN ? 32'h8000_0102 : 0));
        rows.push_back(r(1, 0, 1, 32'h8000_0201, 0, 0, 1, 1,
                         AEN ? 32'h8000_0400 : 32'h8000_0200, 0, AEN, AEN ? 32'h8000_0201 : 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL misalign[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
        mpc_hold = AEN ? 32'h8000_0201 : 32'h0;
    endtask

    task automatic test_wrap();
        row_t rows[$];
        rows.push_back(r(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 0, 0, mpc_hold));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0000, 0, 0, mpc_hold));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0004, 0, 0, mpc_hold));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t        rows[$];
        logic [31:0] p;
        logic        rdy;
        p = 32'h0000_0004;
        for (int k = 0; k < 20; k++) begin
            rdy = 1'($urandom_range(0, 1));
            if (rdy) p = p + 32'd4;
            rows.push_back(r(1, 0, 0, 0, 0, 0, rdy, 1, p, 0, 0, mpc_hold));
        end
        foreach (rows[i]) begin
            drive(rows[i]);
            @(posedge clk); #1;
            obs  = {req_valid, req_pc, halted, misalign, misalign_pc};
            expv = exp_q.pop_front();
            n_cmp++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got v=%b pc=%h h=%b m=%b mpc=%h, want v=%b pc=%h h=%b m=%b mpc=%h",
                         i, obs[66], obs[65:34], obs[33], obs[32], obs[31:0],
                         expv[66], expv[65:34], expv[33], expv[32], expv[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot_sequence();
        test_stall();
        test_redirect_priority();
        test_halt();
        test_misalign();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
